// File: rtl/prog_run_sequencer.sv
// prog_run_sequencer: clocked FSM that selects the next program, holds the CPU in init, then times the run until Halt (watchdog under PROG_SEQ_TIMEOUT_EN)
module prog_run_sequencer #(
  parameter int NUM_PROGS      = 3,
  parameter int INIT_CYCLES    = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               CLK,
  input  logic                               Reset_n,
  input  logic                               Start,
  input  logic                               Halt,
  output logic [$clog2(NUM_PROGS+1)-1:0]     ProgSel,
  output logic                               CpuInit,
  output logic                               Busy,
  output logic                               Done,
  output logic [CNT_W-1:0]                   CycleCount,
  output logic                               TimedOut
);
  localparam int PSW = $clog2(NUM_PROGS + 1);
  localparam int IW  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
`ifdef PROG_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [PSW-1:0]   PS_LAST   = PSW'(NUM_PROGS);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PSW-1:0]   progsel_q, progsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    icnt_q, icnt_d;
  logic             to_q, to_d;
  logic             cpuinit_q, busy_q, done_q;
  logic             wd;

  // Next state: accept Start only in IDLE/DONE, Halt only in RUN; Halt beats the watchdog
  always_comb begin
    state_d   = state_q;
    progsel_d = progsel_q;
    cnt_d     = cnt_q;
    icnt_d    = icnt_q;
    to_d      = to_q;
    wd        = TO_EN && (cnt_q == TO_LAST) && !Halt;
    case (state_q)
      IDLE, DONE: if (Start) begin
        state_d   = INIT;
        progsel_d = (progsel_q == PS_LAST) ? PSW'(1) : progsel_q + PSW'(1);
        cnt_d     = '0;
        icnt_d    = '0;
        to_d      = 1'b0;
      end
      INIT: begin
        state_d = (icnt_q == INIT_LAST) ? RUN : INIT;
        icnt_d  = (icnt_q == INIT_LAST) ? icnt_q : icnt_q + IW'(1);
      end
      RUN: begin
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = (Halt || wd) ? DONE : RUN;
        to_d    = !Halt && wd;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      progsel_q <= '0;
      cnt_q     <= '0;
      icnt_q    <= '0;
      to_q      <= 1'b0;
      cpuinit_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      progsel_q <= progsel_d;
      cnt_q     <= cnt_d;
      icnt_q    <= icnt_d;
      to_q      <= to_d;
      cpuinit_q <= state_d != RUN;
      busy_q    <= (state_d == INIT) || (state_d == RUN);
      done_q    <= state_d == DONE;
    end
  end

  assign ProgSel    = progsel_q;
  assign CpuInit    = cpuinit_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;
  assign TimedOut   = to_q;
endmodule

// File: tb/tb_prog_run_sequencer.sv
// tb_prog_run_sequencer: scoreboard bench for prog_run_sequencer (defaults, TIMEOUT_CYCLES=8)
module tb_prog_run_sequencer;
  logic        clk = 0;
  logic        rst_n, start, halt;
  logic [1:0]  prog_sel;
  logic        cpu_init, busy, done, timed_out;
  logic [15:0] cycle_count;

  typedef struct {int ps; int cnt; int to;} exp_t;
  exp_t sb[$];
  int   checks = 0, failures = 0, exp_ps = 0;

  prog_run_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(2), .CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
    .CLK(clk), .Reset_n(rst_n), .Start(start), .Halt(halt), .ProgSel(prog_sel),
    .CpuInit(cpu_init), .Busy(busy), .Done(done), .CycleCount(cycle_count), .TimedOut(timed_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic next_ps();
    exp_ps = (exp_ps == 3) ? 1 : exp_ps + 1;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin n++; @(negedge clk); end
    chk("done_seen", done, 1);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("sb_progsel", prog_sel, e.ps);
    chk("sb_count", cycle_count, e.cnt);
    chk("sb_timedout", timed_out, e.to);
    chk("sb_cpuinit", cpu_init, 1);
    chk("sb_busy", busy, 0);
  endtask

  task automatic start_run(input bit noise, input bit halt_init);
    int n = 0;
    next_ps();
    start = 1;
    halt  = halt_init;
    @(negedge clk);
    start = noise;
    chk("accept_ps", prog_sel, exp_ps);
    chk("init_busy", busy, 1);
    chk("init_count_clr", cycle_count, 0);
    while (cpu_init && n < 20) begin n++; @(negedge clk); end
    start = 0;
    chk("init_len", n, 2);
  endtask

  task automatic run(input int n_halt, input bit noise, input bit halt_init);
    exp_t e;
    e.cnt = n_halt + 1;
    e.to  = 0;
    start_run(noise, halt_init);
    e.ps = exp_ps;
    sb.push_back(e);
    for (int i = 0; i < n_halt; i++) begin
      start = noise && (i == 1);
      @(negedge clk);
    end
    chk("run_count", cycle_count, n_halt);
    halt  = 1;
    start = noise;
    @(negedge clk);
    halt  = 0;
    start = 0;
    wait_done(50);
    sb_pop();
    @(negedge clk);
    chk("done_hold", done, 1);
    chk("done_frozen", cycle_count, n_halt + 1);
    chk("done_ps", prog_sel, exp_ps);
  endtask

  initial begin
    rst_n = 0; start = 0; halt = 0;
    repeat (2) @(negedge clk);
    chk("rst_ps", prog_sel, 0);
    chk("rst_cpuinit", cpu_init, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_to", timed_out, 0);
    rst_n = 1;
    halt  = 1;
    repeat (3) @(negedge clk);
    halt = 0;
    chk("idle_halt_ignored", busy | done, 0);
    run(10, 0, 0);
    run(3, 1, 0);
    run(0, 0, 1);
    run(4, 1, 0);
    start = 1;
    @(negedge clk);
    @(negedge clk);
    start = 0;
    next_ps();
    chk("held_start_once", prog_sel, exp_ps);
    begin
      int n = 0;
      while (cpu_init && n < 20) begin n++; @(negedge clk); end
    end
    halt = 1;
    @(negedge clk);
    halt = 0;
    wait_done(20);
    chk("held_run_ps", prog_sel, exp_ps);
    chk("held_run_cnt", cycle_count, 1);
    start_run(0, 0);
    repeat (5) @(negedge clk);
    chk("mid_count", cycle_count, 5);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_ps = 0;
    chk("mid_rst_ps", prog_sel, 0);
    chk("mid_rst_count", cycle_count, 0);
    chk("mid_rst_cpuinit", cpu_init, 1);
    chk("mid_rst_busy", busy, 0);
    start_run(0, 0);
`ifdef PROG_SEQ_TIMEOUT_EN
    begin
      exp_t e;
      e.ps = exp_ps; e.cnt = 8; e.to = 1;
      sb.push_back(e);
      wait_done(50);
      sb_pop();
      @(negedge clk);
      chk("wd_hold", done, 1);
    end
`else
    begin
      int drops = 0;
      for (int i = 0; i < 100; i++) begin
        if (!busy) drops++;
        @(negedge clk);
      end
      chk("wd_off_busy", drops, 0);
      chk("wd_off_count", cycle_count, 100);
      chk("wd_off_to", timed_out, 0);
    end
`endif
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
